// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, imem req/ack handshake, IF/ID buffer, branch redirect
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_pc4,
  input  logic [31:0] branch_imm,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc4
);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

  state_t      state, state_next;
  logic [31:0] pc;
  logic [31:0] req_addr;
  logic [31:0] req_addr_pc4;
  logic [31:0] branch_target;
  logic        can_issue;

  assign imem_req      = (state != IDLE);
  assign imem_addr     = req_addr;
  assign req_addr_pc4  = req_addr + 32'd4;
  assign branch_target = (branch_pc4 + (branch_imm << 2)) & 32'hFFFF_FFFC;
  // A new fetch may start when the buffer is empty or is being consumed this cycle.
  assign can_issue     = !branch_taken && (!if_valid || !stall);

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (can_issue) state_next = REQ;
      end
      REQ: begin
        if (imem_ack)          state_next = IDLE;
        else if (branch_taken) state_next = DRAIN;
      end
      DRAIN: begin
        if (imem_ack) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // A branch overrides everything but reset: redirect pc and flush the buffer;
  // a same-cycle ack in REQ is dropped because no load happens on this path.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc       <= RESET_PC;
      req_addr <= RESET_PC;
      if_valid <= 1'b0;
      if_instr <= 32'h0;
      if_pc4   <= 32'h0;
    end else if (branch_taken) begin
      pc       <= branch_target;
      if_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (can_issue) begin
            req_addr <= pc;
            if_valid <= 1'b0;
          end
        end
        REQ: begin
          if (imem_ack) begin
            if_instr <= imem_rdata;
            if_pc4   <= req_addr_pc4;
            if_valid <= 1'b1;
            pc       <= req_addr_pc4;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

  logic        clock;
  logic        reset;

  logic        imem_req0, imem_ack0, if_valid0;
  logic [31:0] imem_addr0, imem_rdata0, if_instr0, if_pc40;
  logic        stall0, branch_taken0;
  logic [31:0] branch_pc40, branch_imm0;
  logic        auto_ack, man_ack;

  logic        imem_req1, if_valid1;
  logic [31:0] imem_addr1, if_instr1, if_pc41;

  int n_checks;
  int n_fail;

  localparam logic [31:0] TAG = 32'hC0DE_0000;

  assign imem_ack0   = auto_ack ? imem_req0 : man_ack;
  assign imem_rdata0 = imem_addr0 ^ TAG;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut0 (
    .clock(clock), .reset(reset),
    .imem_req(imem_req0), .imem_addr(imem_addr0),
    .imem_ack(imem_ack0), .imem_rdata(imem_rdata0),
    .stall(stall0), .branch_taken(branch_taken0),
    .branch_pc4(branch_pc40), .branch_imm(branch_imm0),
    .if_valid(if_valid0), .if_instr(if_instr0), .if_pc4(if_pc40)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
    .clock(clock), .reset(reset),
    .imem_req(imem_req1), .imem_addr(imem_addr1),
    .imem_ack(imem_req1), .imem_rdata(32'h1234_5678),
    .stall(1'b0), .branch_taken(1'b0),
    .branch_pc4(32'h0), .branch_imm(32'h0),
    .if_valid(if_valid1), .if_instr(if_instr1), .if_pc4(if_pc41)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b1;
    stall0 = 1'b0;
    branch_taken0 = 1'b0;
    branch_pc40 = 32'h0;
    branch_imm0 = 32'h0;
    auto_ack = 1'b1;
    man_ack = 1'b0;

    tick();
    tick();
    check_eq("rst_req",   {31'h0, imem_req0}, 32'h0);
    check_eq("rst_valid", {31'h0, if_valid0}, 32'h0);
    check_eq("rst_instr", if_instr0, 32'h0);
    check_eq("rst_pc4",   if_pc40, 32'h0);
    check_eq("rst_addr",  imem_addr0, 32'h0);
    reset = 1'b0;

    // zero-wait streaming: request at 0,4,8 with one-cycle gaps
    tick();
    check_eq("req0",      {31'h0, imem_req0}, 32'h1);
    check_eq("addr0",     imem_addr0, 32'h0000_0000);
    check_eq("wrap_req",  {31'h0, imem_req1}, 32'h1);
    check_eq("wrap_addr", imem_addr1, 32'hFFFF_FFFC);
    tick();
    check_eq("valid0",     {31'h0, if_valid0}, 32'h1);
    check_eq("instr0",     if_instr0, 32'hC0DE_0000);
    check_eq("pc4_0",      if_pc40, 32'h0000_0004);
    check_eq("idle_req",   {31'h0, imem_req0}, 32'h0);
    check_eq("wrap_instr", if_instr1, 32'h1234_5678);
    check_eq("wrap_pc4",   if_pc41, 32'h0000_0000);
    tick();
    check_eq("addr1",      imem_addr0, 32'h0000_0004);
    check_eq("valid_gap",  {31'h0, if_valid0}, 32'h0);
    check_eq("wrap_next",  imem_addr1, 32'h0000_0000);
    tick();
    check_eq("instr1", if_instr0, 32'hC0DE_0004);
    check_eq("pc4_1",  if_pc40, 32'h0000_0008);
    tick();
    check_eq("addr2",  imem_addr0, 32'h0000_0008);
    tick();
    check_eq("valid2", {31'h0, if_valid0}, 32'h1);
    check_eq("pc4_2",  if_pc40, 32'h0000_000C);

    // stall holds the buffer and blocks new requests
    stall0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("stall_valid", {31'h0, if_valid0}, 32'h1);
      check_eq("stall_instr", if_instr0, 32'hC0DE_0008);
      check_eq("stall_pc4",   if_pc40, 32'h0000_000C);
      check_eq("stall_req",   {31'h0, imem_req0}, 32'h0);
    end
    stall0 = 1'b0;
    tick();
    check_eq("unstall_req",  {31'h0, imem_req0}, 32'h1);
    check_eq("unstall_addr", imem_addr0, 32'h0000_000C);
    tick();
    check_eq("unstall_pc4", if_pc40, 32'h0000_0010);

    // branch in IDLE with a valid buffer: 0x10 + (-2<<2) = 0x08
    branch_taken0 = 1'b1;
    branch_pc40 = 32'h0000_0010;
    branch_imm0 = 32'hFFFF_FFFE;
    tick();
    branch_taken0 = 1'b0;
    check_eq("br_idle_valid", {31'h0, if_valid0}, 32'h0);
    check_eq("br_idle_req",   {31'h0, imem_req0}, 32'h0);
    tick();
    check_eq("br_idle_addr", imem_addr0, 32'h0000_0008);
    tick();
    check_eq("br_idle_pc4", if_pc40, 32'h0000_000C);

    // branch and stall together: branch wins, target 0x1C + 4 = 0x20
    stall0 = 1'b1;
    branch_taken0 = 1'b1;
    branch_pc40 = 32'h0000_001C;
    branch_imm0 = 32'h0000_0001;
    tick();
    stall0 = 1'b0;
    branch_taken0 = 1'b0;
    check_eq("br_stall_valid", {31'h0, if_valid0}, 32'h0);
    auto_ack = 1'b0;
    tick();
    check_eq("drain_addr0", imem_addr0, 32'h0000_0020);

    // branch during an outstanding request; low target bits forced to 00
    branch_taken0 = 1'b1;
    branch_pc40 = 32'h0000_0103;
    branch_imm0 = 32'h0000_0010;
    tick();
    branch_taken0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_eq("drain_req",   {31'h0, imem_req0}, 32'h1);
      check_eq("drain_addr",  imem_addr0, 32'h0000_0020);
      check_eq("drain_valid", {31'h0, if_valid0}, 32'h0);
      if (i < 2) tick();
    end
    man_ack = 1'b1;
    tick();
    man_ack = 1'b0;
    check_eq("drain_done_valid", {31'h0, if_valid0}, 32'h0);
    check_eq("drain_done_req",   {31'h0, imem_req0}, 32'h0);
    tick();
    check_eq("br_target_addr", imem_addr0, 32'h0000_0140);
    check_eq("br_target_req",  {31'h0, imem_req0}, 32'h1);

    // reset during outstanding request, ack arrives right after reset
    reset = 1'b1;
    tick();
    reset = 1'b0;
    man_ack = 1'b1;
    check_eq("mid_rst_req",   {31'h0, imem_req0}, 32'h0);
    check_eq("mid_rst_valid", {31'h0, if_valid0}, 32'h0);
    tick();
    man_ack = 1'b0;
    check_eq("post_rst_valid", {31'h0, if_valid0}, 32'h0);
    check_eq("post_rst_req",   {31'h0, imem_req0}, 32'h1);
    check_eq("post_rst_addr",  imem_addr0, 32'h0000_0000);
    tick();
    check_eq("post_rst_hold",  {31'h0, if_valid0}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
